// File: rtl/phase_display_driver.sv
// Four-digit multiplexed seven-segment driver for the phase timer display.
// Layout, left to right: 'P', phase digit, tens of remaining seconds, units.
// The inputs are sampled into shadow registers once per frame so the display never tears mid-frame.
// When set is high, the phase digit's decimal point is lit and the two seconds digits blink.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-low reset, blanks the display immediately
//   set        set-mode flag, used unregistered for the dp and blink gating
//   cur_phase  phase index 0..4; 5..7 are shown as dashes
//   seven_num  remaining seconds 0..15
//   an         digit enables, active-low, an[3] is the leftmost digit
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
module phase_display_driver #(
  parameter int SCAN_DIV  = 25000,
  parameter int BLINK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [2:0] cur_phase,
  input  logic [3:0] seven_num,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [1:0]         slot;
  logic [2:0]         sh_phase;
  logic [3:0]         sh_num;

  logic               tick;
  logic               load;
  logic [1:0]         slot_nx;
  logic [2:0]         phase_nx;
  logic [3:0]         num_nx;
  logic [3:0]         units;
  logic               phase_bad;
  logic [3:0]         an_nx;
  logic [6:0]         seg_nx;
  logic               dp_nx;

  assign tick = (scan_cnt == SCAN_MAX);
  // Shadows reload as the scan wraps from slot 3 back to slot 0.
  assign load = tick && (slot == 2'd3);

  // Output decode looks at the values the shadows will hold after this edge,
  // so slot 0 shows a freshly loaded number on the same edge as the load.
  always_comb begin
    slot_nx   = slot + 2'd1;
    phase_nx  = load ? cur_phase : sh_phase;
    num_nx    = load ? seven_num : sh_num;
    phase_bad = (phase_nx > 3'd4);
    units     = (num_nx >= 4'd10) ? (num_nx - 4'd10) : num_nx;
    an_nx     = ~(4'b0001 << slot_nx);
    dp_nx     = ~(set && (slot_nx == 2'd2));
    seg_nx    = SEG_BLANK;
    case (slot_nx)
      2'd0:    seg_nx = phase_bad ? SEG_DASH : digit_seg(units);
      2'd1:    seg_nx = phase_bad ? SEG_DASH
                                  : ((num_nx >= 4'd10) ? digit_seg(4'd1) : SEG_BLANK);
      2'd2:    seg_nx = phase_bad ? SEG_DASH : digit_seg({1'b0, phase_nx});
      default: seg_nx = SEG_P;
    endcase
    // Blink only the seconds digits (slots 0 and 1) during the off half.
    if (set && !blink_on && !slot_nx[1]) begin
      seg_nx = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      slot     <= 2'd3;
      sh_phase <= 3'd0;
      sh_num   <= 4'd0;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else if (tick) begin
      scan_cnt <= '0;
      slot     <= slot_nx;
      sh_phase <= phase_nx;
      sh_num   <= num_nx;
      an       <= an_nx;
      seg      <= seg_nx;
      dp       <= dp_nx;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink timebase runs only in set mode; leaving set mode forces the
  // digits back on at the next clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!set) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule
